// File: rtl/wrr_bus_arbiter.sv
// Weighted round-robin bus arbiter: registered one-hot grant with a
// runtime-programmable active-master count and per-master burst weights.
module wrr_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int WEIGHT_WIDTH   = 4,
  parameter int DEFAULT_WEIGHT = 1,
  parameter int CFG_ADDR_WIDTH = 5,
  localparam int ID_WIDTH      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_MASTERS-1:0]    req,
  output logic [NUM_MASTERS-1:0]    grant,
  output logic                      grant_valid,
  output logic [ID_WIDTH-1:0]       grant_id,
  input  logic                      config_wr,
  input  logic [CFG_ADDR_WIDTH-1:0] config_addr,
  input  logic [7:0]                config_data
);

  localparam int CNT_W = $clog2(NUM_MASTERS + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state, state_nxt;
  logic [ID_WIDTH-1:0]     ptr, ptr_nxt, ptr_eff, winner, grant_id_nxt;
  logic [WEIGHT_WIDTH-1:0] quota, quota_nxt;
  logic [CNT_W-1:0]        num_active;
  logic [WEIGHT_WIDTH-1:0] weight [NUM_MASTERS];
  logic [NUM_MASTERS-1:0]  eligible, grant_nxt;
  logic                    found, hold;
  logic [4:0]              cfg_count;
  logic [WEIGHT_WIDTH-1:0] cfg_weight;
  int                      idx;
  logic                    unused_cfg;

  assign cfg_count  = config_data[4:0];
  assign cfg_weight = config_data[WEIGHT_WIDTH-1:0];
  assign unused_cfg = &{1'b0, config_data};

  // Configuration registers; writes never stall arbitration.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_active <= CNT_W'(NUM_MASTERS);
      for (int k = 0; k < NUM_MASTERS; k++)
        weight[k] <= WEIGHT_WIDTH'(DEFAULT_WEIGHT);
    end else if (config_wr) begin
      if (config_addr == '0) begin
        if (cfg_count != 5'd0 && int'(cfg_count) <= NUM_MASTERS)
          num_active <= CNT_W'(cfg_count);
      end
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (config_addr == CFG_ADDR_WIDTH'(k + 1))
          weight[k] <= (cfg_weight == '0) ? WEIGHT_WIDTH'(1) : cfg_weight;
      end
    end
  end

  // Round-robin search from ptr, wrapping at num_active rather than NUM_MASTERS.
  always_comb begin
    eligible = '0;
    found    = 1'b0;
    winner   = '0;
    idx      = 0;
    for (int i = 0; i < NUM_MASTERS; i++)
      eligible[i] = req[i] && (i < int'(num_active));
    ptr_eff = (int'(ptr) >= int'(num_active)) ? '0 : ptr;
    for (int off = 0; off < NUM_MASTERS; off++) begin
      if (!found && off < int'(num_active)) begin
        idx = int'(ptr_eff) + off;
        if (idx >= int'(num_active))
          idx = idx - int'(num_active);
        if (eligible[idx]) begin
          found  = 1'b1;
          winner = ID_WIDTH'(idx);
        end
      end
    end
  end

  assign hold = (state == BUSY) && eligible[grant_id] && (quota != '0);

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    quota_nxt    = quota;
    grant_nxt    = grant;
    grant_id_nxt = grant_id;
    if (hold) begin
      quota_nxt = quota - 1'b1;
    end else if (found) begin
      state_nxt         = BUSY;
      grant_nxt         = '0;
      grant_nxt[winner] = 1'b1;
      grant_id_nxt      = winner;
      quota_nxt         = weight[winner] - 1'b1;
      ptr_nxt           = (int'(winner) + 1 >= int'(num_active)) ? '0 : winner + 1'b1;
    end else begin
      state_nxt    = IDLE;
      grant_nxt    = '0;
      grant_id_nxt = '0;
      quota_nxt    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= '0;
      quota       <= '0;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      quota       <= quota_nxt;
      grant       <= grant_nxt;
      grant_id    <= grant_id_nxt;
      grant_valid <= |grant_nxt;
    end
  end

endmodule

// File: tb/tb_wrr_bus_arbiter.sv
// Directed self-checking bench for wrr_bus_arbiter with hand-computed
// grant sequences for rotation, weights, active count and reset.
module tb_wrr_bus_arbiter;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       config_wr;
  logic [4:0] config_addr;
  logic [7:0] config_data;

  int n_compared;
  int n_mismatched;

  wrr_bus_arbiter #(
    .NUM_MASTERS(4), .WEIGHT_WIDTH(4), .DEFAULT_WEIGHT(1), .CFG_ADDR_WIDTH(5)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .grant(grant),
    .grant_valid(grant_valid), .grant_id(grant_id), .config_wr(config_wr),
    .config_addr(config_addr), .config_data(config_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    req         = '0;
    config_wr   = 1'b0;
    config_addr = '0;
    config_data = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic cfg_write(input logic [4:0] addr, input logic [7:0] data);
    config_wr   = 1'b1;
    config_addr = addr;
    config_data = data;
    tick();
    config_wr   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset_n = 1'b0;
    #2;
    n_compared++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outputs: grant=%b valid=%b id=%0d expected 0000/0/0", grant, grant_valid, grant_id);
    end
    tick();
    reset_n = 1'b1;
    req = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_compared++;
      if (grant !== 4'b0001 || grant_valid !== 1'b1 || grant_id !== 2'd0) begin
        n_mismatched++;
        $display("[TB] FAIL single_req_c%0d: grant=%b valid=%b id=%0d expected 0001/1/0", c, grant, grant_valid, grant_id);
      end
    end
    req = 4'b0000;
    tick();
    n_compared++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      n_mismatched++;
      $display("[TB] FAIL single_release: grant=%b valid=%b id=%0d expected 0000/0/0", grant, grant_valid, grant_id);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_compared++;
      if (grant !== exp_g[c] || grant_id !== exp_id[c] || grant_valid !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL rotation_c%0d: grant=%b id=%0d valid=%b expected %b/%0d/1", c, grant, grant_id, grant_valid, exp_g[c], exp_id[c]);
      end
    end
  endtask

  task automatic test_weighted();
    logic [3:0] exp_g [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010,
                              4'b0001, 4'b0001, 4'b0001, 4'b0010};
    do_reset();
    cfg_write(5'd1, 8'd3);
    cfg_write(5'd2, 8'd1);
    req = 4'b0011;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_compared++;
      if (grant !== exp_g[c] || grant_valid !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL weighted_c%0d: grant=%b valid=%b expected %b/1", c, grant, grant_valid, exp_g[c]);
      end
    end
  endtask

  task automatic test_active_count();
    logic [3:0] exp_a [6] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
    logic [3:0] exp_b [3] = '{4'b0001, 4'b0010, 4'b0001};
    logic [3:0] exp_c [5] = '{4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    cfg_write(5'd0, 8'd2);
    req = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_compared++;
      if (grant !== exp_a[c]) begin
        n_mismatched++;
        $display("[TB] FAIL active2_c%0d: grant=%b expected %b", c, grant, exp_a[c]);
      end
    end
    config_wr = 1'b1; config_addr = 5'd0; config_data = 8'd0;
    for (int c = 0; c < 3; c++) begin
      tick();
      config_wr = 1'b0;
      n_compared++;
      if (grant !== exp_b[c]) begin
        n_mismatched++;
        $display("[TB] FAIL active0_ignored_c%0d: grant=%b expected %b", c, grant, exp_b[c]);
      end
    end
    config_wr = 1'b1; config_addr = 5'd0; config_data = 8'd4;
    for (int c = 0; c < 5; c++) begin
      tick();
      config_wr = 1'b0;
      n_compared++;
      if (grant !== exp_c[c]) begin
        n_mismatched++;
        $display("[TB] FAIL active4_c%0d: grant=%b expected %b", c, grant, exp_c[c]);
      end
    end
  endtask

  task automatic test_inactive_masters();
    do_reset();
    cfg_write(5'd0, 8'd2);
    cfg_write(5'd0, 8'd5);
    req = 4'b1100;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_compared++;
      if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
        n_mismatched++;
        $display("[TB] FAIL inactive_c%0d: grant=%b valid=%b id=%0d expected 0000/0/0", c, grant, grant_valid, grant_id);
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    cfg_write(5'd1, 8'd4);
    req = 4'b0011;
    tick();
    tick();
    n_compared++;
    if (grant !== 4'b0001) begin
      n_mismatched++;
      $display("[TB] FAIL early_owned: grant=%b expected 0001", grant);
    end
    req = 4'b0010;
    tick();
    n_compared++;
    if (grant !== 4'b0010 || grant_valid !== 1'b1 || grant_id !== 2'd1) begin
      n_mismatched++;
      $display("[TB] FAIL early_handover: grant=%b valid=%b id=%0d expected 0010/1/1", grant, grant_valid, grant_id);
    end
  endtask

  task automatic test_back_to_back_reset();
    logic [3:0] exp_g [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    cfg_write(5'd3, 8'd5);
    cfg_write(5'd0, 8'd3);
    req = 4'b0100;
    tick();
    tick();
    n_compared++;
    if (grant !== 4'b0100) begin
      n_mismatched++;
      $display("[TB] FAIL midburst_held: grant=%b expected 0100", grant);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_compared++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset: grant=%b valid=%b id=%0d expected 0000/0/0", grant, grant_valid, grant_id);
    end
    tick();
    reset_n = 1'b1;
    req = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_compared++;
      if (grant !== exp_g[c]) begin
        n_mismatched++;
        $display("[TB] FAIL post_reset_c%0d: grant=%b expected %b", c, grant, exp_g[c]);
      end
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    test_reset();
    test_rotation();
    test_weighted();
    test_active_count();
    test_inactive_masters();
    test_early_release();
    test_back_to_back_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
